axis_main_wrapper: RTL and testbench

Self-contained AXI-Stream pattern buffer. While `enable` is high it fills an internal RAM of `MEM_SIZE` words with a counting pattern (slave/fill side). It then streams the RAM contents out on an AXI4-Stream master port and marks the final word with `tlast`. It sits at the top of the lab datapath as a traffic source for downstream AXI-Stream consumers.

---
 rtl/main_wrapper_pkg.sv | 25 ++
 rtl/main_wrapper_ram.sv | 25 ++
 rtl/axis_main_wrapper.sv | 127 ++++++++++++
 tb/tb_axis_main_wrapper.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/main_wrapper_pkg.sv
// Shared types and helpers for the axis_main_wrapper pattern buffer.
// Optional continuous-frame mode is selected with the MAIN_WRAPPER_LOOP_EN macro.
package main_wrapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // The pointers must be able to address every buffered word.
  function automatic bit ptr_width_ok(input int mem_size, input int addr_width);
    return (mem_size >= 2) && (longint'(mem_size) <= (longint'(1) << addr_width));
  endfunction

endpackage

// File: rtl/main_wrapper_ram.sv
// Single-port synchronous RAM for the pattern buffer: write enable, registered read, no reset.
module main_wrapper_ram
  import main_wrapper_pkg::*;
#(
  parameter int MEM_SIZE   = 64,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AW     = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [RAM_AW-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/axis_main_wrapper.sv
// AXI-Stream pattern source: fills a RAM with a counting pattern, then streams it out with tlast.
// Define MAIN_WRAPPER_LOOP_EN to restart the fill after each frame instead of stopping in DONE.
module axis_main_wrapper
  import main_wrapper_pkg::*;
#(
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s03_axis_aclk,
  input  logic                    s03_axis_aresetn,
  input  logic                    enable,
  output logic                    s03_axis_tready,
  input  logic                    m03_axis_tready,
  output logic [DATA_WIDTH-1:0]   m03_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m03_axis_tstrb,
  output logic                    m03_axis_tvalid,
  output logic                    m03_axis_tlast
);

  localparam int                    STRB_W   = strb_width(DATA_WIDTH);
  localparam int                    RAM_AW   = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_SIZE - 1);

  if (!ptr_width_ok(MEM_SIZE, ADDR_WIDTH) || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("axis_main_wrapper: unsupported MEM_SIZE/ADDR_WIDTH/DATA_WIDTH combination");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic                    tvalid_q, tvalid_d;
  logic                    s_tready_q;
  logic                    ram_we;
  logic [RAM_AW-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    hs;

  assign hs = tvalid_q & m03_axis_tready;

  // The RAM read register is the output data register; the read address runs one word
  // ahead on a handshake so a new word is presented every cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    ram_we   = 1'b0;
    ram_addr = RAM_AW'(rd_ptr_q);
    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
        ram_addr = RAM_AW'(wr_ptr_q);
        if (enable) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_LOAD: begin
        ram_addr = '0;
        state_d  = ST_STREAM;
        tvalid_d = 1'b1;
      end
      ST_STREAM: begin
        if (hs) begin
          if (rd_ptr_q == LAST_PTR) begin
            state_d  = ST_DONE;
            tvalid_d = 1'b0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            ram_addr = RAM_AW'(rd_ptr_d);
          end
        end
      end
      ST_DONE: begin
`ifdef MAIN_WRAPPER_LOOP_EN
        state_d = ST_FILL;
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s03_axis_aclk or negedge s03_axis_aresetn) begin
    if (!s03_axis_aresetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tvalid_q   <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tvalid_q   <= tvalid_d;
      s_tready_q <= (state_d == ST_FILL);
    end
  end

  main_wrapper_ram #(
    .MEM_SIZE  (MEM_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_AW    (RAM_AW)
  ) u_ram (
    .clk_i  (s03_axis_aclk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(DATA_WIDTH'(wr_ptr_q)),
    .rdata_o(ram_rdata)
  );

  // RAM has no reset, so gating with tvalid keeps the outputs at 0 during and after reset.
  assign s03_axis_tready = s_tready_q;
  assign m03_axis_tvalid = tvalid_q;
  assign m03_axis_tdata  = tvalid_q ? ram_rdata : '0;
  assign m03_axis_tstrb  = {STRB_W{tvalid_q}};
  assign m03_axis_tlast  = tvalid_q && (rd_ptr_q == LAST_PTR);

endmodule

// File: tb/tb_axis_main_wrapper.sv
// Directed/randomized bench for axis_main_wrapper: expected frame built as the list 0..MEM_SIZE-1.
`timescale 1ns/1ps
module tb_axis_main_wrapper;

  localparam int MEM_SIZE   = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_W     = DATA_WIDTH / 8;

  logic                  clk      = 1'b0;
  logic                  rst_n    = 1'b0;
  logic                  enable   = 1'b0;
  logic                  m_tready = 1'b0;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_W-1:0]     tstrb;
  logic                  tvalid;
  logic                  tlast;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_main_wrapper #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .s03_axis_aclk   (clk),
    .s03_axis_aresetn(rst_n),
    .enable          (enable),
    .s03_axis_tready (s_tready),
    .m03_axis_tready (m_tready),
    .m03_axis_tdata  (tdata),
    .m03_axis_tstrb  (tstrb),
    .m03_axis_tvalid (tvalid),
    .m03_axis_tlast  (tlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"},  tdata,  0);
    chk({tag, "_tstrb"},  tstrb,  0);
    chk({tag, "_tlast"},  tlast,  0);
  endtask

  // mode 0: enable high except a directed pause; mode 1: random enable (0, X or 1).
  // A word is written on every edge seen in FILL with enable high.
  task automatic fill(input int mode, input int pause_after, input int pause_len);
    int writes = 0;
    int cyc    = 0;
    int paused = 0;
    int r;
    while (writes < MEM_SIZE && cyc < 8 * MEM_SIZE + 100) begin
      if (mode == 0) begin
        if (writes == pause_after && paused < pause_len) begin
          enable = 1'b0;
          paused++;
        end else begin
          enable = 1'b1;
        end
      end else begin
        r = $urandom_range(0, 3);
        enable = (r == 0) ? 1'b0 : (r == 1) ? 1'bx : 1'b1;
      end
      step();
      cyc++;
      if (enable === 1'b1) writes++;
      if (writes < MEM_SIZE) begin
        chk("fill_s_tready", s_tready, 1);
        chk("fill_tvalid", tvalid, 0);
      end
    end
    enable = 1'b0;
    if (writes < MEM_SIZE) timeout_fail("fill");
    chk("load_tvalid", tvalid, 0);
    chk("load_s_tready", s_tready, 0);
    step();
  endtask

  // mode 0: tready high except a directed stall; mode 1: random tready (0, X or 1).
  task automatic stream(input int mode, input int bp_at, input int bp_len,
                        input int abort_at, output bit aborted);
    int exp_q[$];
    int idx;
    int cyc  = 0;
    int held = 0;
    int r;
    for (int i = 0; i < MEM_SIZE; i++) exp_q.push_back(i);
    aborted = 1'b0;
    while (exp_q.size() > 0 && cyc < 20 * MEM_SIZE) begin
      idx = exp_q[0];
      chk("tvalid", tvalid, 1);
      chk("tdata", tdata, 64'(idx));
      chk("tlast", tlast, (idx == MEM_SIZE - 1) ? 64'd1 : 64'd0);
      chk("tstrb", tstrb, {STRB_W{1'b1}});
      if (idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_s_tready", s_tready, 0);
        aborted = 1'b1;
        return;
      end
      if (mode == 0) begin
        if (idx == bp_at && held < bp_len) begin
          m_tready = 1'b0;
          held++;
        end else begin
          m_tready = 1'b1;
        end
      end else begin
        r = $urandom_range(0, 3);
        m_tready = (r == 0) ? 1'b0 : (r == 1) ? 1'bx : 1'b1;
      end
      step();
      cyc++;
      if (m_tready === 1'b1) void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0) timeout_fail("stream");
    m_tready = 1'b1;
    chk_idle("frame_end");
    chk("frame_end_s_tready", s_tready, 0);
  endtask

  initial begin
    bit ab;
    rst_n    = 1'b0;
    enable   = 1'b0;
    m_tready = 1'b0;
    #10;
    chk_idle("reset");
    chk("reset_s_tready", s_tready, 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_reset_s_tready", s_tready, 1);
    chk("post_reset_tvalid", tvalid, 0);

    // First frame: directed fill pause and a 40-cycle stall at word 10.
    while ($time < 200) step();
    m_tready = 1'b1;
    fill(0, 20, 15);
    stream(0, 10, 40, -1, ab);

    for (int k = 0; k < 3; k++) begin
      step();
      chk("after_frame_tvalid", tvalid, 0);
`ifdef MAIN_WRAPPER_LOOP_EN
      chk("after_frame_s_tready", s_tready, 1);
`else
      chk("after_frame_s_tready", s_tready, 0);
`endif
    end
`ifdef MAIN_WRAPPER_LOOP_EN
    fill(1, 0, 0);
    stream(1, -1, 0, -1, ab);
`endif

    // Restart, then abandon the frame with a reset at word 30.
    #2 rst_n = 1'b0;
    #1 chk_idle("reset2");
    #3 rst_n = 1'b1;
    step();
    chk("reset2_s_tready", s_tready, 1);
    fill(1, 0, 0);
    stream(1, -1, 0, 30, ab);
    chk("abort_taken", ab, 1);
    step();
    chk_idle("abort_hold");
    #3 rst_n = 1'b1;
    step();
    chk("abort_release_s_tready", s_tready, 1);
    fill(1, 0, 0);
    stream(1, -1, 0, -1, ab);
    chk("full_frame_after_abort", ab, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
